// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Module  : debug_pkg
// Brief   : Shared encodings and frame-size helper for the debug dump path.
// Revision: 1.0 - initial release
// ============================================================================
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WAIT_MEM = 3'd2,
        SEND     = 3'd3,
        WAIT_TX  = 3'd4,
        DONE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_SEND = 2'd1,
        SER_WAIT = 2'd2
    } ser_state_t;

    typedef enum logic [1:0] {
        SEC_PC  = 2'd0,
        SEC_CYC = 2'd1,
        SEC_REG = 2'd2,
        SEC_MEM = 2'd3
    } section_t;

    localparam int BYTES_PER_WORD = 4;

    // PC word + cycle-count word + register words + memory words.
    function automatic int FRAME_BYTES(input int n_regs, input int n_mem);
        return BYTES_PER_WORD * (2 + n_regs + n_mem);
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module  : word_byte_serializer
// Brief   : Sends one word MSB byte first, one byte per tx_start/tx_done pair.
// Revision: 1.0 - initial release
// ============================================================================
module word_byte_serializer
    import debug_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int N_BITS  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic [NB_DATA-1:0] word_in_i,
    input  logic               tx_done_i,
    output logic               tx_start_o,
    output logic [N_BITS-1:0]  tx_data_o,
    output logic               word_done_o
);

    localparam int c_N_BYTES  = NB_DATA / N_BITS;
    localparam int c_NB_BIDX  = $clog2(c_N_BYTES);
    localparam logic [c_NB_BIDX-1:0] c_LAST_BYTE = c_NB_BIDX'(c_N_BYTES - 1);

    ser_state_t             r_state;
    ser_state_t             w_state_next;
    logic [NB_DATA-1:0]     r_buffer;
    logic [c_NB_BIDX-1:0]   r_byte_idx;
    logic [N_BITS-1:0]      r_tx_data;
    logic                   w_byte_adv;
    logic                   w_word_done;

    always_comb begin
        w_state_next = r_state;
        w_byte_adv   = 1'b0;
        w_word_done  = 1'b0;
        case (r_state)
            SER_IDLE: if (load_i) w_state_next = SER_SEND;
            SER_SEND: w_state_next = SER_WAIT;
            SER_WAIT: begin
                if (tx_done_i) begin
                    if (r_byte_idx == c_LAST_BYTE) begin
                        w_word_done  = 1'b1;
                        w_state_next = SER_IDLE;
                    end else begin
                        w_byte_adv   = 1'b1;
                        w_state_next = SER_SEND;
                    end
                end
            end
            default: w_state_next = SER_IDLE;
        endcase
    end

    // The buffer shifts left per byte so the next byte is always in the top slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= SER_IDLE;
            r_buffer   <= '0;
            r_byte_idx <= '0;
            r_tx_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (load_i && (r_state == SER_IDLE)) begin
                r_buffer   <= word_in_i;
                r_byte_idx <= '0;
                r_tx_data  <= word_in_i[NB_DATA-1 -: N_BITS];
            end else if (w_byte_adv) begin
                r_buffer   <= r_buffer << N_BITS;
                r_byte_idx <= r_byte_idx + 1'b1;
                r_tx_data  <= r_buffer[NB_DATA-N_BITS-1 -: N_BITS];
            end else if (w_word_done) begin
                r_byte_idx <= '0;
            end
        end
    end

    assign tx_start_o  = (r_state == SER_SEND);
    assign tx_data_o   = r_tx_data;
    assign word_done_o = w_word_done;

endmodule
`default_nettype wire

// File: rtl/debug_tx_dumper.sv
`default_nettype none
// ============================================================================
// Module  : debug_tx_dumper
// Brief   : Dumps PC, cycle count, register bank and data memory to tx_uart.
// Revision: 1.0 - initial release
// ============================================================================
module debug_tx_dumper
    import debug_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_REG      = 5,
    parameter int N_BITS      = 8,
    parameter int NB_PC       = 7,
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_i,
    input  logic [NB_PC-1:0]   pc_i,
    input  logic [NB_DATA-1:0] cycle_count_i,
    output logic [NB_REG-1:0]  reg_addr_o,
    input  logic [NB_DATA-1:0] reg_data_i,
    output logic [NB_PC-1:0]   mem_addr_o,
    input  logic [NB_DATA-1:0] mem_data_i,
    output logic               tx_start_o,
    output logic [N_BITS-1:0]  tx_data_o,
    input  logic               tx_done_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int c_NB_IDX = ((NB_PC > NB_REG) ? NB_PC : NB_REG) + 1;
    localparam logic [c_NB_IDX-1:0] c_LAST_REG = c_NB_IDX'(N_REGS - 1);
    localparam logic [c_NB_IDX-1:0] c_LAST_MEM =
        c_NB_IDX'((N_MEM_WORDS > 0) ? (N_MEM_WORDS - 1) : 0);
    localparam bit c_HAS_MEM = (N_MEM_WORDS > 0);

    state_t                r_state, w_state_next;
    section_t              r_sec, w_sec_next;
    logic [c_NB_IDX-1:0]   r_word_idx, w_idx_next, w_idx_inc;
    logic [NB_PC-1:0]      r_mem_addr, w_mem_addr_next;
    logic [NB_PC-1:0]      r_pc_snap;
    logic [NB_DATA-1:0]    r_cyc_snap;
    logic                  w_load;
    logic [NB_DATA-1:0]    w_word_in;
    logic                  w_word_done;

    assign w_idx_inc = r_word_idx + 1'b1;

    always_comb begin
        w_state_next    = r_state;
        w_sec_next      = r_sec;
        w_idx_next      = r_word_idx;
        w_mem_addr_next = r_mem_addr;
        w_load          = 1'b0;
        w_word_in       = '0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_sec_next      = SEC_PC;
                    w_idx_next      = '0;
                    w_mem_addr_next = '0;
                    w_state_next    = LOAD;
                end
            end
            LOAD: begin
                case (r_sec)
                    SEC_PC: begin
                        w_load       = 1'b1;
                        w_word_in    = {{(NB_DATA-NB_PC){1'b0}}, r_pc_snap};
                        w_state_next = SEND;
                    end
                    SEC_CYC: begin
                        w_load       = 1'b1;
                        w_word_in    = r_cyc_snap;
                        w_state_next = SEND;
                    end
                    SEC_REG: begin
                        w_load       = 1'b1;
                        w_word_in    = reg_data_i;
                        w_state_next = SEND;
                    end
                    SEC_MEM: w_state_next = WAIT_MEM;
                    default: w_state_next = IDLE;
                endcase
            end
            WAIT_MEM: begin
                w_load       = 1'b1;
                w_word_in    = mem_data_i;
                w_state_next = SEND;
            end
            SEND: w_state_next = WAIT_TX;
            WAIT_TX: begin
                if (w_word_done) begin
                    w_state_next = LOAD;
                    case (r_sec)
                        SEC_PC:  w_sec_next = SEC_CYC;
                        SEC_CYC: begin
                            w_sec_next = SEC_REG;
                            w_idx_next = '0;
                        end
                        SEC_REG: begin
                            if (r_word_idx == c_LAST_REG) begin
                                if (c_HAS_MEM) begin
                                    w_sec_next      = SEC_MEM;
                                    w_idx_next      = '0;
                                    w_mem_addr_next = '0;
                                end else begin
                                    w_state_next = DONE;
                                end
                            end else begin
                                w_idx_next = w_idx_inc;
                            end
                        end
                        SEC_MEM: begin
                            if (r_word_idx == c_LAST_MEM) begin
                                w_state_next = DONE;
                            end else begin
                                w_idx_next      = w_idx_inc;
                                w_mem_addr_next = {w_idx_inc[NB_PC-3:0], 2'b00};
                            end
                        end
                        default: w_state_next = IDLE;
                    endcase
                end else if (tx_done_i) begin
                    w_state_next = SEND;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_sec      <= SEC_PC;
            r_word_idx <= '0;
            r_mem_addr <= '0;
            r_pc_snap  <= '0;
            r_cyc_snap <= '0;
        end else begin
            r_state    <= w_state_next;
            r_sec      <= w_sec_next;
            r_word_idx <= w_idx_next;
            r_mem_addr <= w_mem_addr_next;
            if ((r_state == IDLE) && start_i) begin
                r_pc_snap  <= pc_i;
                r_cyc_snap <= cycle_count_i;
            end
        end
    end

    word_byte_serializer #(
        .NB_DATA (NB_DATA),
        .N_BITS  (N_BITS)
    ) u_serializer (
        .clock       (clock),
        .reset       (reset),
        .load_i      (w_load),
        .word_in_i   (w_word_in),
        .tx_done_i   (tx_done_i),
        .tx_start_o  (tx_start_o),
        .tx_data_o   (tx_data_o),
        .word_done_o (w_word_done)
    );

    assign reg_addr_o = (r_sec == SEC_REG) ? r_word_idx[NB_REG-1:0] : '0;
    assign mem_addr_o = r_mem_addr;
    assign busy_o     = (r_state != IDLE) && (r_state != DONE);
    assign done_o     = (r_state == DONE);

endmodule
`default_nettype wire

// File: doc/debug_tx_dumper.md
Name: debug_tx_dumper

Overview:
- Downstream consumer of the pipeline state and upstream feeder of tx_uart.
- On a start pulse from debug_unit it snapshots PC and cycle count, then walks the register bank and data memory.
- Every 32-bit word is serialized MSB-first into bytes, one byte per tx_uart handshake (tx_start / tx_done_tick).
- busy_o stalls the pipeline (en_pipeline gated low) so register and memory reads stay stable for the whole dump.

Parameters:
- NB_DATA, 32, word width of registers, memory and cycle counter
- NB_REG, 5, register address width
- N_BITS, 8, UART byte width
- NB_PC, 7, PC / data-memory byte-address width
- N_REGS, 32, registers dumped, indices 0..N_REGS-1
- N_MEM_WORDS, 32, data-memory words dumped; must satisfy N_MEM_WORDS*4 <= 2^NB_PC

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start_i  in  1  dump request; sampled only in IDLE
- pc_i  in  NB_PC  current PC, snapshotted on accept
- cycle_count_i  in  NB_DATA  executed-cycle count, snapshotted on accept
- reg_addr_o  out  NB_REG  register-bank read address
- reg_data_i  in  NB_DATA  register read data, combinational (same cycle)
- mem_addr_o  out  NB_PC  data-memory byte address, word index*4
- mem_data_i  in  NB_DATA  data-memory read data, valid one cycle after mem_addr_o
- tx_start_o  out  1  one-cycle pulse: tx_data_o is valid, start transmission
- tx_data_o  out  N_BITS  byte to transmit
- tx_done_i  in  1  tx_uart tx_done_tick
- busy_o  out  1  dump in progress
- done_o  out  1  one-cycle pulse at end of dump

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0; word buffer, byte index, word index and section cleared.
- Frame, strictly in this order, each word MSB byte first:
  - PC zero-extended to NB_DATA (4 bytes)
  - cycle count (4 bytes)
  - reg[0..N_REGS-1]
  - mem word[0..N_MEM_WORDS-1]
  - Default total = 8 + 128 + 128 = 264 bytes.
- Sections: SEC_PC, SEC_CYC, SEC_REG, SEC_MEM. The word index restarts at 0 at each section boundary.
- FSM states: IDLE, LOAD, WAIT_MEM, SEND, WAIT_TX, DONE.
- IDLE:
  - busy_o=0.
  - start_i=1 at cycle k: latch pc_i and cycle_count_i, section=SEC_PC, go to LOAD at k+1; busy_o=1 from k+1.
- LOAD:
  - SEC_PC / SEC_CYC: buffer <= snapshot.
  - SEC_REG: buffer <= reg_data_i with reg_addr_o = word index, go to SEND.
  - SEC_MEM: mem_addr_o already holds index*4 (registered when the index advances), go to WAIT_MEM.
- WAIT_MEM: buffer <= mem_data_i, go to SEND.
- SEND:
  - tx_start_o=1 for exactly this cycle; tx_data_o = buffer[31:24] for byte 0, down to [7:0] for byte 3.
  - Go to WAIT_TX. tx_data_o holds its value until the next SEND.
- WAIT_TX, on tx_done_i:
  - byte index < 3: increment it, go to SEND.
  - byte index = 3: clear it, advance word / section, go to LOAD.
  - After the last memory word's last byte: go to DONE.
- DONE:
  - done_o=1 and busy_o=0 for one cycle, then IDLE.
  - A start_i in DONE is ignored; a new dump needs start_i in IDLE.
- Latency:
  - First tx_start_o at k+2 for PC/CYC/REG, k+3 for a memory word.
  - Byte-to-byte gap after tx_done_i = 1 cycle.
- Boundary conditions:
  - start_i while busy: ignored.
  - tx_done_i outside WAIT_TX: ignored (no counter change).
  - tx_done_i coincident with SEND: ignored.
  - pc_i / cycle_count_i changes after accept: no effect.
  - N_MEM_WORDS=0: SEC_MEM is skipped; DONE follows the last register.
  - reset low mid-dump: immediate IDLE; the partial frame is abandoned; the next start_i restarts at PC byte 0.

Decomposition:
- Shared package debug_pkg:
  - state encoding
  - section codes SEC_PC..SEC_MEM
  - BYTES_PER_WORD=4
  - FRAME_BYTES function of N_REGS / N_MEM_WORDS
- One natural sub-module: word_byte_serializer.
  - Owns the 32-bit buffer, the byte index and the SEND/WAIT_TX handshake.
  - load/word_in inputs; word_done output.
  - The parent FSM sequences sections and addresses.

Test Plan:
1. Reset asserted mid-idle, then released → all outputs 0, busy_o=0, no tx_start_o for 20 cycles with tx_done_i toggling.
2. Full dump, tx_done_i returned 3 cycles after each tx_start_o:
   - Stimulus: pc_i=7'h14, cycle_count_i=32'h123, reg[i]=i*32'h01010101, mem[i]=32'hDEAD0000+i.
   - Expect exactly 264 tx_start_o pulses; bytes 00 00 00 14 00 00 01 23 00 00 00 00 01 01 01 01 … DE AD 00 1F.
   - Expect one done_o; busy_o high from k+1 to the cycle before DONE.
3. start_i re-pulsed at byte 50 and pc_i changed to 7'h40 → frame unchanged and still 264 bytes, PC bytes 00 00 00 14.
4. Spurious tx_done_i during LOAD and WAIT_MEM, plus tx_done_i coincident with SEND → byte and word counters unchanged, frame identical to scenario 2.
5. reset low at byte 100 for 1 cycle, then start_i → tx_start_o low immediately; the new frame begins 00 00 00 <pc_i>.
6. Parameter N_MEM_WORDS=1 → 140 bytes; mem_addr_o=0 only; last bytes DE AD 00 00, then done_o.
